// File: rtl/apb_pkg.sv
// Shared types for the APB master: FSM state encoding and the queued command entry.
package apb_pkg;

    // Widest configuration a command entry can carry; narrower instances zero-extend.
    localparam int unsigned SEL_MAX   = 16;
    localparam int unsigned ADDR_MAX  = 32;
    localparam int unsigned WDATA_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic                 write;
        logic [SEL_MAX-1:0]   sel;
        logic [ADDR_MAX-1:0]  addr;
        logic [WDATA_MAX-1:0] wdata;
    } cmd_entry_t;

    // True when exactly one bit of the select is set.
    function automatic logic is_onehot(input logic [SEL_MAX-1:0] v);
        return (v != '0) && ((v & (v - SEL_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/apb_master_cmd_fifo.sv
// Command FIFO: show-ahead head, wrap-around pointers, registered flags.
module apb_master_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             empty,
    output logic             full,
    output logic             space
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // Pointers, occupancy and flags; space is low throughout reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            space  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CNT_W'(DEPTH));
            space <= (count_d != CNT_W'(DEPTH));
        end
    end

    // Entry storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/apb_master.sv
// APB master: queues commands, runs SETUP/ACCESS transfers, returns in-order responses.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned SEL_WIDTH   = 2,
    parameter int unsigned WRITE_WIDTH = 32,
    parameter int unsigned READ_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [SEL_WIDTH-1:0]   cmd_sel,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [WRITE_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic [READ_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err,
    output logic [SEL_WIDTH-1:0]   sel,
    output logic                   enable,
    output logic                   write,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [WRITE_WIDTH-1:0] wdata,
    input  logic [READ_WIDTH-1:0]  rdata,
    input  logic                   ready,
    input  logic                   slv_err
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_t                 state_q;
    state_t                 state_d;
    cmd_entry_t             push_entry;
    cmd_entry_t             head;
    logic                   head_ok;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    logic                   load;
    logic [WAIT_W-1:0]      wait_q;
    logic [WAIT_W-1:0]      wait_d;
    logic [SEL_WIDTH-1:0]   sel_d;
    logic                   enable_d;
    logic                   write_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [WRITE_WIDTH-1:0] wdata_d;
    logic                   rsp_valid_d;
    logic [READ_WIDTH-1:0]  rsp_rdata_d;
    logic                   rsp_err_d;
    logic                   unused_head;

    assign push        = cmd_valid && cmd_ready && !fifo_full;
    assign head_ok     = is_onehot(head.sel);
    assign unused_head = ^head;

    // Zero-extend the incoming command into the shared entry layout.
    always_comb begin
        push_entry       = '0;
        push_entry.write = cmd_write;
        push_entry.sel   = SEL_MAX'(cmd_sel);
        push_entry.addr  = ADDR_MAX'(cmd_addr);
        push_entry.wdata = WDATA_MAX'(cmd_wdata);
    end

    apb_master_cmd_fifo #(
        .WIDTH ($bits(cmd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_c    (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .space     (cmd_ready)
    );

    // Next state, FIFO pop and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        load        = 1'b0;
        wait_d      = wait_q;
        sel_d       = sel;
        enable_d    = enable;
        write_d     = write;
        addr_d      = addr;
        wdata_d     = wdata;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        load    = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        // Bad select: no bus cycle, error response next cycle.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                enable_d = 1'b1;
                wait_d   = '0;
                state_d  = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (ready || (wait_q == WAIT_W'(TIMEOUT - 1))) begin
                    rsp_valid_d = 1'b1;
                    if (ready) begin
                        rsp_rdata_d = write ? '0 : rdata;
                        rsp_err_d   = slv_err;
                    end else begin
                        rsp_err_d   = 1'b1;
                    end
                    enable_d = 1'b0;
                    wait_d   = '0;
                    // Chain straight into SETUP only for a valid head; a bad
                    // select is answered from IDLE so responses never collide.
                    if (!fifo_empty && head_ok) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        sel_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                sel_d    = '0;
                enable_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        if (load) begin
            sel_d   = SEL_WIDTH'(head.sel);
            write_d = head.write;
            addr_d  = ADDR_WIDTH'(head.addr);
            wdata_d = WRITE_WIDTH'(head.wdata);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // APB, response and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q    <= '0;
            sel       <= '0;
            enable    <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            sel       <= sel_d;
            enable    <= enable_d;
            write     <= write_d;
            addr      <= addr_d;
            wdata     <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 SHALL have parameter SEL_WIDTH, default 2, one-hot slave-select width.
REQ-003 SHALL have parameter WRITE_WIDTH, default 32, APB write-data width.
REQ-004 SHALL have parameter READ_WIDTH, default 32, APB read-data width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries, power of two, minimum 2.
REQ-006 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles before abort, minimum 1.
REQ-007 The block SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock.
- reset  in  1  async active-high reset.
REQ-008 Command port, valid/ready:
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1=write, 0=read.
- cmd_sel  in  SEL_WIDTH  one-hot target.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  WRITE_WIDTH  write data.
REQ-009 Response port, no backpressure:
- rsp_valid  out  1  one-cycle pulse.
- rsp_rdata  out  READ_WIDTH  read data (0 for writes).
- rsp_err  out  1  slave error, timeout or bad select.
REQ-010 APB side:
- sel  out  SEL_WIDTH  select.
- enable  out  1  access phase.
- write  out  1  direction.
- addr  out  ADDR_WIDTH  address.
- wdata  out  WRITE_WIDTH  write data.
- rdata  in  READ_WIDTH  read data.
- ready  in  1  slave ready.
- slv_err  in  1  slave error.

Function
REQ-011 A command SHALL be pushed when cmd_valid and cmd_ready are both high on a clk edge; cmd_ready SHALL be low only when the FIFO holds FIFO_DEPTH entries.
REQ-012 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-013 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry, register sel/write/addr/wdata, and enter SETUP on the next cycle.
REQ-014 SETUP SHALL last exactly one cycle, with sel equal to cmd_sel and enable=0; the FSM then enters ACCESS with enable=1 and all other APB outputs held stable.
REQ-015 ready SHALL be sampled only in ACCESS; ready in IDLE or SETUP SHALL be ignored.
REQ-016 In ACCESS with ready=1, the block SHALL pulse rsp_valid for one cycle with rsp_rdata=rdata (reads) and rsp_err=slv_err, and SHALL deassert enable.
REQ-017 On ACCESS completion, with the FIFO non-empty, the FSM SHALL go directly to SETUP (back-to-back transfers, no IDLE cycle); otherwise it goes to IDLE with sel=0.
REQ-018 A wait counter SHALL count ACCESS cycles with ready=0; on reaching TIMEOUT, the transfer SHALL be aborted with rsp_valid=1, rsp_err=1, rsp_rdata=0, and the FSM proceeds as in REQ-017.
REQ-019 A popped command with cmd_sel not exactly one-hot (including 0) SHALL produce no APB transfer, and one cycle later SHALL give rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-020 Responses SHALL be returned in command order, one per accepted command.
REQ-021 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged; a push when the FIFO is full SHALL have no effect.
REQ-022 sel and enable SHALL never both be zero during SETUP or ACCESS; enable SHALL never be 1 while sel=0.

Reset
REQ-023 While reset is high, all of the following SHALL be 0: state=IDLE, FIFO empty, cmd_ready, sel, enable, write, addr, wdata, rsp_valid, rsp_rdata, rsp_err, wait counter.
REQ-024 A reset during SETUP or ACCESS SHALL discard the in-flight transfer and all queued commands with no response; cmd_ready SHALL rise on the first clk edge after reset falls.

Structure
REQ-025 The state enum (IDLE/SETUP/ACCESS) and the command-entry packed struct SHALL live in package apb_pkg.
REQ-026 The command FIFO SHALL be the sub-module apb_master_cmd_fifo, parameterised by width and FIFO_DEPTH, with full/empty flags and wrap-around pointers.

Verification
REQ-027 Write 0xDEADBEEF to sel=01, addr=0x10; slave ready on the first ACCESS cycle -> 1 SETUP + 1 ACCESS cycle, rsp_valid with rsp_err=0.
REQ-028 Read addr=0x10 after REQ-027 with a 3-cycle ready delay -> enable held for 4 cycles, rsp_rdata=0xDEADBEEF.
REQ-029 Push 5 commands back-to-back with FIFO_DEPTH=4 while the bus is stalled -> cmd_ready=0 after the 4th push; all 5 complete in order with no IDLE cycle between them.
REQ-030 Slave never asserts ready, TIMEOUT=16 -> abort after 16 ACCESS cycles with rsp_err=1; the next queued command proceeds normally.
REQ-031 cmd_sel=00, then cmd_sel=11 -> no bus activity, and two error responses.
REQ-032 Assert reset mid-ACCESS with 2 commands queued -> all outputs 0, no rsp_valid, FIFO empty after release.
